// File: rtl/dti_apb_master.sv
// APB3 initiator bridging a valid/ready load-store channel onto APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
`ifndef CFG_APB_ADDR_WIDTH
`define CFG_APB_ADDR_WIDTH 32
`endif
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

module dti_apb_master #(
  parameter int APB_ADDR_WIDTH = `CFG_APB_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = `CFG_APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      apb_pclk,
  input  logic                      apb_preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_r;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_r;
`else
  logic tmo_cfg_unused_s;
  assign tmo_cfg_unused_s = (TIMEOUT_CYCLES > 1);
`endif

  // Accept a request only when idle and the response slot is free or draining this cycle.
  always_comb begin
    req_ready = 1'b0;
    if (!apb_preset && (state_r == IDLE)) begin
      req_ready = !rsp_valid || rsp_ready;
    end else begin
      req_ready = 1'b0;
    end
  end

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge apb_pclk or posedge apb_preset) begin
    if (apb_preset) begin
      state_r     <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      apb_paddr   <= '0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_pwdata  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_r   <= 16'd0;
`endif
    end else begin
      // A completion below overrides this clear when both happen together.
      if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            apb_paddr  <= req_addr;
            apb_pwrite <= req_write;
            apb_pwdata <= req_wdata;
            apb_psel   <= 1'b1;
            state_r    <= SETUP;
          end
        end
        SETUP: begin
          apb_penable <= 1'b1;
          state_r     <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_r   <= 16'd0;
`endif
        end
        ACCESS: begin
          if (apb_pready) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= apb_pslverr;
            rsp_rdata   <= (!apb_pwrite && !apb_pslverr) ? apb_prdata : '0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            state_r     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LIMIT) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            state_r     <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
`endif
        end
        default: begin
          apb_psel    <= 1'b0;
          apb_penable <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dti_apb_master.sv
// Randomized self-checking bench for dti_apb_master with a transaction-level slave/memory model.
`ifndef CFG_APB_ADDR_WIDTH
`define CFG_APB_ADDR_WIDTH 32
`endif
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

module tb_dti_apb_master;
  localparam int AW = `CFG_APB_ADDR_WIDTH;
  localparam int DW = `CFG_APB_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, apb_prdata = '0;
  logic          apb_pready = 1'b0, apb_pslverr = 1'b0;
  logic          req_ready, rsp_valid, rsp_err, apb_psel, apb_penable, apb_pwrite;
  logic [DW-1:0] rsp_rdata, apb_pwdata;
  logic [AW-1:0] apb_paddr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [16];
  logic          pend = 1'b0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] exp_rdata = '0;

  dti_apb_master #(
`ifdef APB_MASTER_TIMEOUT_EN
    .TIMEOUT_CYCLES(4),
`endif
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)
  ) dut (
    .apb_pclk(clk), .apb_preset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request (draining any pending response after 'stall' cycles), run SETUP.
  task automatic issue(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                       input int stall);
    req_valid = 1'b1; req_addr = a; req_write = wr; req_wdata = wd;
    if (pend) begin
      rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("bp_req_ready", req_ready, 1'b0);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("bp_rsp_rdata", rsp_rdata, exp_rdata);
        chk("bp_rsp_err", rsp_err, exp_err);
        next_cycle();
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("req_ready", req_ready, 1'b1);
    next_cycle();
    req_valid = 1'b0; rsp_ready = 1'b0; pend = 1'b0;
    req_addr = AW'($urandom); req_wdata = DW'($urandom); req_write = ~wr;
    @(negedge clk);
    chk("setup_psel", apb_psel, 1'b1);
    chk("setup_penable", apb_penable, 1'b0);
    chk("setup_paddr", apb_paddr, a);
    chk("setup_pwrite", apb_pwrite, wr);
    if (wr) chk("setup_pwdata", apb_pwdata, wd);
    chk("setup_rsp_clear", rsp_valid, 1'b0);
    next_cycle();
  endtask

  // One complete transfer against the memory model with 'waits' wait states.
  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                      input int waits, input logic err, input int stall);
    int idx;
    idx = int'(a[5:2]);
    issue(a, wr, wd, stall);
    for (int w = 0; w <= waits; w++) begin
      apb_pready  = (w == waits);
      apb_pslverr = apb_pready ? err : 1'($urandom);
      apb_prdata  = !apb_pready ? DW'($urandom) : (err ? '1 : mem[idx]);
      @(negedge clk);
      chk("acc_psel", apb_psel, 1'b1);
      chk("acc_penable", apb_penable, 1'b1);
      chk("acc_paddr", apb_paddr, a);
      chk("acc_pwrite", apb_pwrite, wr);
      chk("acc_rsp_valid", rsp_valid, 1'b0);
      next_cycle();
    end
    apb_pready = 1'b0; apb_pslverr = 1'b0;
    exp_err   = err;
    exp_rdata = (!wr && !err) ? mem[idx] : '0;
    if (wr && !err) mem[idx] = wd;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("done_psel", apb_psel, 1'b0);
    chk("done_penable", apb_penable, 1'b0);
    chk("done_paddr_held", apb_paddr, a);
    pend = 1'b1;
    next_cycle();
  endtask

  task automatic drain();
    if (pend) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("drain_valid", rsp_valid, 1'b1);
      next_cycle();
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("drain_clear", rsp_valid, 1'b0);
      next_cycle();
      pend = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    mem[8] = 32'h1234_5678;
    #2;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_psel", apb_psel, 1'b0);
    chk("rst_penable", apb_penable, 1'b0);
    chk("rst_paddr", apb_paddr, '0);
    chk("rst_pwdata", apb_pwdata, '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 0);
    xfer(32'h0000_0020, 1'b0, '0, 3, 1'b0, 0);
    chk("dir_read_val", exp_rdata, 32'h1234_5678);
    xfer(32'h0000_0030, 1'b0, '0, 0, 1'b1, 2);
    xfer(32'h0000_0010, 1'b0, '0, 1, 1'b0, 5);
    chk("dir_readback", exp_rdata, 32'hDEAD_BEEF);

    for (int t = 0; t < 40; t++) begin
      xfer(AW'($urandom) & AW'(32'hFFFF_FFFC), 1'($urandom), DW'($urandom),
           int'($urandom_range(4, 0)), ($urandom_range(7, 0) == 0), int'($urandom_range(3, 0)));
    end
    drain();

    // Reset in the middle of ACCESS discards the transfer.
    issue(32'h0000_0044, 1'b1, 32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("pre_rst_penable", apb_penable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_psel", apb_psel, 1'b0);
    chk("mid_rst_penable", apb_penable, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp", rsp_valid, 1'b0);
      chk("post_rst_psel", apb_psel, 1'b0);
      next_cycle();
    end
    xfer(32'h0000_0044, 1'b0, '0, 2, 1'b0, 0);
    drain();

    // Slave that never raises pready.
    issue(32'h0000_0008, 1'b0, '0, 0);
    apb_pready = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      apb_prdata = DW'($urandom) | DW'(1);
      @(negedge clk);
      chk("tmo_penable", apb_penable, 1'b1);
      chk("tmo_rsp_wait", rsp_valid, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    chk("tmo_rsp_valid", rsp_valid, 1'b1);
    chk("tmo_rsp_err", rsp_err, 1'b1);
    chk("tmo_rsp_rdata", rsp_rdata, '0);
    chk("tmo_psel", apb_psel, 1'b0);
    chk("tmo_penable_off", apb_penable, 1'b0);
    pend = 1'b1;
    next_cycle();
`else
    begin
      logic still;
      still = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (!(apb_psel && apb_penable && !rsp_valid)) still = 1'b0;
        next_cycle();
      end
      chk("no_timeout_hold", still, 1'b1);
    end
    apb_pready = 1'b1; apb_pslverr = 1'b0; apb_prdata = 32'hA5A5_0F0F;
    next_cycle();
    apb_pready = 1'b0;
    @(negedge clk);
    chk("late_rsp_valid", rsp_valid, 1'b1);
    chk("late_rsp_err", rsp_err, 1'b0);
    chk("late_rsp_rdata", rsp_rdata, 32'hA5A5_0F0F);
    pend = 1'b1;
    next_cycle();
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
